// File: rtl/keypad_entry_if.sv
// Output bundle of keypad_entry: decoded key, entry register and publish pulse.
// The keypad itself (row/col) and the buttons stay as plain ports on the top.
interface keypad_entry_if;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic [15:0] data;
    logic [2:0]  digit_count;
    logic        data_valid;

    modport master (
        output key_code, key_strobe, data, digit_count, data_valid
    );

    modport slave (
        input key_code, key_strobe, data, digit_count, data_valid
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner, debouncer and 16-bit entry register with enter/clear.
// Optional macro KEYPAD_SATURATE_EN: stop shifting data once four digits are held.
module keypad_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] col,
    keypad_entry_if.master bus
);
    localparam int DWW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SBW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DWW-1:0] DWELL_LAST  = DWW'(SCAN_DIV - 1);
    localparam logic [SBW-1:0] STABLE_LAST = SBW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE_ST, HOLD} state_t;

    state_t         state;
    logic [1:0]     col_idx;
    logic [DWW-1:0] dwell;
    logic [SBW-1:0] stable;
    logic [1:0]     row_lat;

    logic [3:0] row_s1, row_s2;
    logic       enter_s1, enter_s2, enter_prev;
    logic       clear_s1, clear_s2, clear_prev;

    logic       enter_edge, clear_edge;
    logic [3:0] row_low;
    logic       single;
    logic [1:0] row_idx;
    logic [3:0] code;
    logic       accept;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        col_drive = ~(4'b0001 << idx);
    endfunction

    // Button syncs reset high so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1     <= 4'hF;
            row_s2     <= 4'hF;
            enter_s1   <= 1'b1;
            enter_s2   <= 1'b1;
            enter_prev <= 1'b1;
            clear_s1   <= 1'b1;
            clear_s2   <= 1'b1;
            clear_prev <= 1'b1;
        end else begin
            row_s1     <= row;
            row_s2     <= row_s1;
            enter_s1   <= btn_enter;
            enter_s2   <= enter_s1;
            enter_prev <= enter_s2;
            clear_s1   <= btn_clear;
            clear_s2   <= clear_s1;
            clear_prev <= clear_s2;
        end
    end

    assign enter_edge = enter_s2 & ~enter_prev;
    assign clear_edge = clear_s2 & ~clear_prev;

    always_comb begin
        row_low = ~row_s2;
        single  = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);
        unique case (row_low)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        code   = {row_idx, col_idx};
        accept = (state == DEBOUNCE_ST) && single && (row_idx == row_lat)
                 && (stable == STABLE_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= SCAN;
            col_idx         <= 2'd0;
            col             <= 4'b1110;
            dwell           <= '0;
            stable          <= '0;
            row_lat         <= 2'd0;
            bus.key_code    <= 4'h0;
            bus.key_strobe  <= 1'b0;
            bus.data        <= 16'h0000;
            bus.digit_count <= 3'd0;
            bus.data_valid  <= 1'b0;
        end else begin
            bus.key_strobe <= 1'b0;
            bus.data_valid <= 1'b0;

            unique case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (single) begin
                            row_lat <= row_idx;
                            stable  <= '0;
                            state   <= DEBOUNCE_ST;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col     <= col_drive(col_idx + 2'd1);
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE_ST: begin
                    if (single && (row_idx == row_lat)) begin
                        if (stable == STABLE_LAST) begin
                            stable <= '0;
                            state  <= HOLD;
                        end else begin
                            stable <= stable + 1'b1;
                        end
                    end else begin
                        stable  <= '0;
                        state   <= SCAN;
                        col_idx <= col_idx + 2'd1;
                        col     <= col_drive(col_idx + 2'd1);
                    end
                end
                HOLD: begin
                    if (row_s2 == 4'hF) begin
                        if (stable == STABLE_LAST) begin
                            stable  <= '0;
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                            col     <= col_drive(col_idx + 2'd1);
                        end else begin
                            stable <= stable + 1'b1;
                        end
                    end else begin
                        stable <= '0;
                    end
                end
                default: state <= SCAN;
            endcase

            // Clear outranks enter, and either one swallows a coincident key.
            if (clear_edge) begin
                bus.data        <= 16'h0000;
                bus.digit_count <= 3'd0;
            end else if (enter_edge) begin
                if (bus.digit_count != 3'd0) begin
                    bus.data_valid  <= 1'b1;
                    bus.digit_count <= 3'd0;
                end
            end else if (accept) begin
                bus.key_strobe <= 1'b1;
                bus.key_code   <= code;
`ifdef KEYPAD_SATURATE_EN
                if (bus.digit_count != 3'd4)
                    bus.data <= {bus.data[11:0], code};
`else
                bus.data <= {bus.data[11:0], code};
`endif
                if (bus.digit_count != 3'd4)
                    bus.digit_count <= bus.digit_count + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives row from col, a monitor
// pops expected strobes/publishes from queues. Honours KEYPAD_SATURATE_EN if defined.
module tb_keypad_entry;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 8;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
        logic [2:0]  count;
    } key_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic       btn_enter;
    logic       btn_clear;

    logic       press_en;
    logic       press2_en;
    int         press_r;
    int         press2_r;
    int         press_c;

    key_exp_t    key_q[$];
    logic [15:0] dv_q[$];
    logic [15:0] model_data;
    int          model_count;

    int checks   = 0;
    int failures = 0;

    keypad_entry_if bus ();

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .col       (col),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low only while its column is driven.
    always_comb begin
        row = 4'hF;
        if (press_en && !col[press_c])
            row[press_r] = 1'b0;
        if (press2_en && !col[press_c])
            row[press2_r] = 1'b0;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        key_exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (bus.data_valid === 1'b1) begin
                    if (dv_q.size() == 0) begin
                        check_output("unexpected_data_valid", 32'd1, 32'd0);
                    end else begin
                        check_output("publish_data", {16'h0, bus.data}, {16'h0, dv_q.pop_front()});
                    end
                end
                if (bus.key_strobe === 1'b1) begin
                    if (key_q.size() == 0) begin
                        check_output("unexpected_key_strobe", 32'd1, 32'd0);
                    end else begin
                        e = key_q.pop_front();
                        check_output("key_code", {28'h0, bus.key_code}, {28'h0, e.code});
                        @(negedge clk);
                        check_output("strobe_width", {31'h0, bus.key_strobe}, 32'd0);
                        check_output("key_data", {16'h0, bus.data}, {16'h0, e.data});
                        check_output("key_count", {29'h0, bus.digit_count}, {29'h0, e.count});
                    end
                end
            end
        end
    end

    task automatic wait_strobe(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.key_strobe === 1'b1) seen = 1'b1;
        end
        if (!seen) check_output(name, 32'd0, 32'd1);
    endtask

    task automatic expect_key(input int r, input int c);
        key_exp_t e;
        logic [3:0] code;
        code = 4'(4 * r + c);
`ifdef KEYPAD_SATURATE_EN
        if (model_count != 4) model_data = {model_data[11:0], code};
`else
        model_data = {model_data[11:0], code};
`endif
        if (model_count < 4) model_count++;
        e.code  = code;
        e.data  = model_data;
        e.count = 3'(model_count);
        key_q.push_back(e);
    endtask

    task automatic apply_key(input int r, input int c);
        expect_key(r, c);
        press_r  = r;
        press_c  = c;
        press_en = 1'b1;
        wait_strobe("key_timeout");
        press_en = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic apply_clear();
        btn_clear = 1'b1;
        repeat (4) @(negedge clk);
        btn_clear = 1'b0;
        repeat (4) @(negedge clk);
        model_data  = 16'h0;
        model_count = 0;
    endtask

    initial begin : stimulus
        int lat;
        logic [3:0] seen_cols;
        reset      = 1'b1;
        btn_enter  = 1'b0;
        btn_clear  = 1'b0;
        press_en   = 1'b0;
        press2_en  = 1'b0;
        press_r    = 0;
        press2_r   = 0;
        press_c    = 0;
        model_data  = 16'h0;
        model_count = 0;

        repeat (3) @(negedge clk);
        check_output("reset_col", {28'h0, col}, 32'hE);
        check_output("reset_data", {16'h0, bus.data}, 32'h0);
        check_output("reset_count", {29'h0, bus.digit_count}, 32'h0);
        check_output("reset_pulses", {30'h0, bus.key_strobe, bus.data_valid}, 32'h0);
        check_output("reset_key_code", {28'h0, bus.key_code}, 32'h0);

        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_output($sformatf("idle_col_%0d", k), {28'h0, col},
                         {28'h0, ~(4'b0001 << ((k / 4) % 4))});
        end

        // Bounced press of key 9 (row 2, column 1)
        press_r = 2;
        press_c = 1;
        for (int i = 0; i < 50 && col != 4'b1101; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            press_en = 1'b1;
            @(negedge clk);
            press_en = 1'b0;
            @(negedge clk);
        end
        expect_key(2, 1);
        press_en = 1'b1;
        wait_strobe("bounce_key_timeout");
        check_output("hold_col_pressed", {28'h0, col}, 32'hD);
        @(negedge clk);
        check_output("key9_data", {16'h0, bus.data}, 32'h0009);
        press_en = 1'b0;
        repeat (5) @(negedge clk);
        check_output("hold_col_released", {28'h0, col}, 32'hD);
        repeat (16) @(negedge clk);

        apply_clear();
        check_output("clear_data", {16'h0, bus.data}, 32'h0);
        check_output("clear_count", {29'h0, bus.digit_count}, 32'h0);

        apply_key(0, 1);
        apply_key(0, 2);
        apply_key(0, 3);
        apply_key(1, 0);
        check_output("data_1234", {16'h0, bus.data}, 32'h1234);
        check_output("count_4", {29'h0, bus.digit_count}, 32'd4);

        dv_q.push_back(16'h1234);
        btn_enter = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.data_valid === 1'b1) lat = i;
        end
        check_output("enter_latency", lat, 32'd3);
        repeat (5) @(negedge clk);
        btn_enter = 1'b0;
        repeat (4) @(negedge clk);
        check_output("enter_count", {29'h0, bus.digit_count}, 32'd0);
        check_output("enter_data", {16'h0, bus.data}, 32'h1234);
        model_count = 0;

        apply_clear();
        apply_key(0, 1);
        apply_key(0, 2);
        apply_key(0, 3);
        apply_key(1, 0);
        apply_key(1, 1);
`ifdef KEYPAD_SATURATE_EN
        check_output("fifth_key_data", {16'h0, bus.data}, 32'h1234);
`else
        check_output("fifth_key_data", {16'h0, bus.data}, 32'h2345);
`endif
        check_output("fifth_key_code", {28'h0, bus.key_code}, 32'h5);
        check_output("fifth_key_count", {29'h0, bus.digit_count}, 32'd4);

        // Two rows low in one column must never register
        press_c   = 2;
        press_r   = 0;
        press2_r  = 3;
        press_en  = 1'b1;
        press2_en = 1'b1;
        seen_cols = 4'h0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            seen_cols = seen_cols | ~col;
        end
        check_output("multi_row_scanning", {28'h0, seen_cols}, 32'hF);
        press_en  = 1'b0;
        press2_en = 1'b0;
        repeat (16) @(negedge clk);

        apply_clear();
        apply_key(2, 2);
        apply_key(2, 3);
        check_output("data_00ab", {16'h0, bus.data}, 32'h00AB);

        btn_clear = 1'b1;
        btn_enter = 1'b1;
        repeat (5) @(negedge clk);
        btn_clear = 1'b0;
        btn_enter = 1'b0;
        repeat (5) @(negedge clk);
        model_data  = 16'h0;
        model_count = 0;
        check_output("clear_enter_data", {16'h0, bus.data}, 32'h0);
        check_output("clear_enter_count", {29'h0, bus.digit_count}, 32'h0);

        btn_enter = 1'b1;
        repeat (5) @(negedge clk);
        btn_enter = 1'b0;
        repeat (8) @(negedge clk);

        check_output("key_queue_drained", key_q.size(), 32'd0);
        check_output("publish_queue_drained", dv_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Input-side counterpart to the seven-segment output path. Scans a 4x4 hex matrix keypad (active-low rows and columns), debounces each press, and decodes it to a 4-bit hex digit. Digits are shifted into a 16-bit entry register. An enter button publishes the entered word to the processor or register file, and a clear button resets the entry. One key is registered per physical press.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before advancing; minimum 4.
- `DEBOUNCE`, default 50000: consecutive stable cycles required to accept a press or a release; minimum 2.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `row` in 4: keypad rows, active-low, asynchronous. Synchronized internally with 2 flops.
- `btn_enter` in 1: enter button, active-high, asynchronous. 2-flop sync plus rising-edge detect.
- `btn_clear` in 1: clear button, active-high, asynchronous. 2-flop sync plus rising-edge detect.
- `col` out 4: column drive, active-low, exactly one bit low at any time.
- `key_code` out 4: last accepted digit.
- `key_strobe` out 1: one-cycle pulse when a digit is accepted.
- `data` out 16: entry register; the newest digit sits in `data[3:0]`.
- `digit_count` out 3: digits entered since the last clear or enter, range 0..4.
- `data_valid` out 1: one-cycle pulse on enter; `data` is stable while it is high.

## Operation
- Reset values:
  - `col=4'b1110`; column index 0.
  - `key_code=0`, `key_strobe=0`, `data=0`, `digit_count=0`, `data_valid=0`.
  - State SCAN; all counters 0; edge detectors primed so a button already held at reset does not fire.
- Key mapping: code = 4*r + c, where r is the index of the low row and c is the column index. Example: r=2, c=1 gives 4'h9.
- A row pattern is a "single key" only when exactly one bit of the synced `row` is low. Zero or multiple low bits are treated as no key.
- FSM states:
  - SCAN: the dwell counter runs 0..SCAN_DIV-1. On the last dwell cycle:
    - single key seen: latch r, advance to DEBOUNCE, keep the column.
    - otherwise: advance the column index modulo 4 (3 wraps to 0).
  - DEBOUNCE: the column is held.
    - Each cycle with the same single row: stable counter +1.
    - Any other pattern: return to SCAN with the counter cleared; the column index advances.
    - Counter reaches DEBOUNCE: accept the key and go to HOLD.
  - HOLD: the column is held.
    - Counter +1 while `row==4'hF`; cleared on any low row.
    - Counter reaches DEBOUNCE: go to SCAN; the column index advances.
- Key accept (one cycle):
  - `key_code`←code; `key_strobe`=1; `data`←{`data[11:0]`, code}; `digit_count`←min(count+1, 4).
- Enter edge:
  - `digit_count`>0: `data_valid`=1, `digit_count`←0, `data` unchanged.
  - `digit_count`==0: ignored; no pulse.
- Clear edge: `data`←0, `digit_count`←0, no `data_valid`.
- Simultaneous events, same cycle, in priority order:
  - Clear beats enter: no pulse.
  - Clear or enter beats a key accept: the key is discarded, with no `key_strobe` and no shift. The FSM still moves to HOLD.
- Reset mid-press: everything returns to reset values. A key still held after reset passes the full SCAN and DEBOUNCE sequence again.

## Timing
- `row` to internal sample: 2 cycles.
- Press to `key_strobe`: at most 2 + 4·SCAN_DIV + DEBOUNCE cycles.
- `key_strobe` and the register update occur in the same cycle. `data` and `digit_count` are registered and valid the cycle after the strobe.
- Button edge to `data_valid`: 3 cycles (2 sync flops + 1 edge register). `data_valid` is registered.
- Pulses last exactly 1 cycle, regardless of how long the key or button is held.
- `col` changes only on FSM transitions out of SCAN dwell end, DEBOUNCE abort, or HOLD exit.

## Configuration
- `KEYPAD_SATURATE_EN`:
  - Defined: once `digit_count`==4, further keys still pulse `key_strobe` and update `key_code`, but `data` is not shifted.
  - Undefined: `data` keeps shifting and the oldest digit is lost from `data[15:12]`; `digit_count` stays at 4.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=8.
- Reset, then idle with `row=4'hF`: `col` cycles 1110→1101→1011→0111→1110, stepping every 4 cycles. No strobes.
- Hold r=2 while c=1 is driven, with 3 bounce toggles first: exactly one `key_strobe`, `key_code`=4'h9, `data`=16'h0009, `digit_count`=1. Col stays 1101 until 8 cycles after release.
- Enter keys 1,2,3,4, then pulse `btn_enter`: `data`=16'h1234; `data_valid` pulses 1 cycle, 3 cycles after the button edge; `digit_count`=0.
- A fifth key 5 after 1234:
  - with `KEYPAD_SATURATE_EN`: `data`=16'h1234.
  - without it: `data`=16'h2345.
  - Both cases: `key_strobe` pulses.
- Hold two rows low in the same column: no strobe; scanning continues.
- Assert `btn_clear` and `btn_enter` in the same cycle with `data`=16'h00AB: `data`=0, `digit_count`=0, no `data_valid`. Then enter with count 0: no pulse.
